// File: rtl/sub4_pkg.sv
// Shared definitions for the bit-serial 4-bit subtractor: state encoding,
// default operand width and bit-counter sizing.
package sub4_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter only needs to index bits 0..width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/sub4_serial_if.sv
// Request/result bus of the serial subtractor.
// Handshake: a request is taken on a rising edge where start=1 and in_ready=1;
// out_valid pulses for one cycle when d/bout carry a new result (no back-pressure).
interface sub4_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             out_valid;

  modport master (
    output start, a, b, bin,
    input  in_ready, d, bout, out_valid
  );

  modport slave (
    input  start, a, b, bin,
    output in_ready, d, bout, out_valid
  );
endinterface

// File: rtl/fsub1.sv
// One-bit full subtractor: d = a - b - bi, bo is the borrow out.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/sub4_serial.sv
// Bit-serial subtractor: one operand bit per cycle, LSB first, result and
// borrow land in registered outputs after WIDTH shift cycles.
module sub4_serial
  import sub4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sub4_serial_if.slave  bus,
  output state_t        state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             bit_d;
  logic             bit_bo;
  logic             load;
  logic             last;

  assign load = (state == IDLE) && bus.start;
  assign last = (cnt == CW'(WIDTH - 1));

  fsub1 u_fsub1 (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .bi (br),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath; the final shift writes straight into the output registers so
  // d/bout stay frozen for the whole operation until that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (load) begin
      sh_a <= bus.a;
      sh_b <= bus.b;
      br   <= bus.bin;
      res  <= '0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      br   <= bit_bo;
      res  <= {bit_d, res[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
      if (last) begin
        d_q    <= {bit_d, res[WIDTH-1:1]};
        bout_q <= bit_bo;
      end
    end
  end

  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_sub4_serial.sv
// Scoreboard bench for sub4_serial: directed vectors plus an exhaustive
// sweep, with a monitor that checks value, latency and output stability.
module tb_sub4_serial;
  import sub4_pkg::*;

  localparam int W  = 4;
  localparam int EW = 32 + 1 + W;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     cyc;
  int     n_chk;
  int     n_fail;
  int     hold_d;
  int     hold_b;

  logic [EW-1:0] exp_q[$];

  sub4_serial_if #(.WIDTH(W)) bus ();

  sub4_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Driver: issue one request, record expected result and completion cycle.
  task automatic issue(input int a, input int b, input int bin,
                       input int exp_d, input int exp_b);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = a[W-1:0];
    bus.b     = b[W-1:0];
    bus.bin   = bin[0];
    exp_q.push_back({32'(cyc + 1 + W), exp_b[0], exp_d[W-1:0]});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 15));
    bus.b     = W'($urandom_range(0, 15));
    bus.bin   = 1'($urandom_range(0, 1));
  endtask

  // Monitor: pop and compare on every out_valid, otherwise outputs must hold.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      hold_d = 0;
      hold_b = 0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result_d", int'(bus.d), int'(e[W-1:0]));
        check("result_bout", int'(bus.bout), int'(e[W]));
        check("latency_cycle", cyc, int'(e[EW-1:W+1]));
        hold_d = int'(e[W-1:0]);
        hold_b = int'(e[W]);
      end
    end else begin
      check("hold_d", int'(bus.d), hold_d);
      check("hold_bout", int'(bus.bout), hold_b);
    end
  end

  initial begin
    int ed;
    int eb;
    n_chk     = 0;
    n_fail    = 0;
    hold_d    = 0;
    hold_b    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_d", int'(bus.d), 0);
    check("reset_bout", int'(bus.bout), 0);
    check("reset_state", int'(state_dbg), int'(IDLE));
    rst_n = 1'b1;

    issue(7, 3, 0, 4, 0);
    issue(3, 7, 0, 12, 1);
    issue(0, 0, 1, 15, 1);
    issue(15, 15, 1, 15, 1);

    // Busy: a second start during SHIFT must be dropped.
    issue(9, 2, 0, 7, 0);
    check("busy_state", int'(state_dbg), int'(SHIFT));
    check("busy_in_ready", int'(bus.in_ready), 0);
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("busy_queue_empty", exp_q.size(), 0);

    // Reset on the second SHIFT cycle aborts the operation.
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'd1;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_d", int'(bus.d), 0);
    check("abort_bout", int'(bus.bout), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_d_after", int'(bus.d), 0);
    check("abort_in_ready_after", int'(bus.in_ready), 1);

    // First operation after reset release.
    issue(1, 2, 1, 14, 1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          ed = (a - b - bin + 32) % 16;
          eb = (a < b + bin) ? 1 : 0;
          issue(a, b, bin, ed, eb);
        end
      end
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
